// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack machine control unit.
// Holds opcode values, FSM state encoding, instruction classes produced by
// the opcode decoder, datapath mux select codes and the packed control word
// that the output ROM produces each cycle.
package stack_ctrl_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_PUSHI = 4'h1;
    localparam logic [3:0] OP_POP   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_BZ    = 4'h8;
    localparam logic [3:0] OP_CALL  = 4'h9;
    localparam logic [3:0] OP_RET   = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Memory port 1 address select
    localparam logic [1:0] MEMDST1_PC  = 2'd0;
    localparam logic [1:0] MEMDST1_MSP = 2'd1;
    // Memory port 2 address select
    localparam logic [1:0] MEMDST2_MSP = 2'd0;
    localparam logic [1:0] MEMDST2_RSP = 2'd1;
    // Memory write data select
    localparam logic [2:0] MEMDATA_PC    = 3'd0;
    localparam logic [2:0] MEMDATA_RES   = 3'd1;
    localparam logic [2:0] MEMDATA_ZEIMM = 3'd2;
    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_PUSH_IMM,
        S_POPA, S_READA, S_POPB, S_READB,
        S_PUSH_RES, S_BZTEST, S_BRANCH, S_RPUSH,
        S_RPOP, S_RREAD, S_JUMPR, S_HALT
    } stateT;

    typedef enum logic [3:0] {
        C_NOP, C_PUSHI, C_POP, C_ALU, C_JMP,
        C_BZ, C_CALL, C_RET, C_HALT, C_ILLEGAL
    } instrClassT;

    typedef struct packed {
        logic       mspWrite;
        logic       mspPop;
        logic       mspRegReset;
        logic       rspWrite;
        logic       rspPop;
        logic       rspRegReset;
        logic       pcWrite;
        logic       pcSource;
        logic       pcAdd;
        logic       pcRegReset;
        logic       valAWrite;
        logic       valBWrite;
        logic       irWrite;
        logic       memRead1;
        logic       memRead2;
        logic       memWrite1;
        logic       memWrite2;
        logic [1:0] memDst1;
        logic [1:0] memDst2;
        logic [2:0] memData;
        logic [2:0] aluOp;
        logic       halted;
    } ctrlT;

endpackage

// File: rtl/stack_opcode_decode.sv
// Combinational opcode decoder.
//   opcode  in   OPW  instruction opcode field
//   instrClass out    instruction class steering the FSM dispatch
//   aluOp   out  3    ALU operation for the ALU class (0 otherwise)
module stack_opcode_decode
    import stack_ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] opcode,
    output instrClassT     instrClass,
    output logic [2:0]     aluOp
);

    always_comb begin
        instrClass = C_ILLEGAL;
        aluOp      = ALU_ADD;
        case (opcode)
            OPW'(OP_NOP):   instrClass = C_NOP;
            OPW'(OP_PUSHI): instrClass = C_PUSHI;
            OPW'(OP_POP):   instrClass = C_POP;
            OPW'(OP_ADD): begin instrClass = C_ALU; aluOp = ALU_ADD; end
            OPW'(OP_SUB): begin instrClass = C_ALU; aluOp = ALU_SUB; end
            OPW'(OP_AND): begin instrClass = C_ALU; aluOp = ALU_AND; end
            OPW'(OP_OR):  begin instrClass = C_ALU; aluOp = ALU_OR;  end
            OPW'(OP_JMP):   instrClass = C_JMP;
            OPW'(OP_BZ):    instrClass = C_BZ;
            OPW'(OP_CALL):  instrClass = C_CALL;
            OPW'(OP_RET):   instrClass = C_RET;
            OPW'(OP_HALT):  instrClass = C_HALT;
            default:        instrClass = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/stack_control_unit.sv
// Multicycle control FSM for the stack-machine datapath.
// Inputs : CLK, Reset (sync, active high), IR (instruction register),
//          ValA (zero test for BZ).
// Outputs: stack pointer, PC, register-write, memory port and mux strobes,
//          ALUOp, Halted, and the sticky Illegal flag.
// All strobes are Moore outputs of the state register, gated to zero in any
// cycle where Reset is asserted.
module stack_control_unit
    import stack_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] IR,
    input  logic [WIDTH-1:0] ValA,
    output logic             MSPWrite,
    output logic             MSPPop,
    output logic             MSPRegReset,
    output logic             RSPWrite,
    output logic             RSPPop,
    output logic             RSPRegReset,
    output logic             PCWrite,
    output logic             PCSource,
    output logic             PCAdd,
    output logic             PCRegReset,
    output logic             ValAWrite,
    output logic             ValBWrite,
    output logic             IRWrite,
    output logic             MemRead1,
    output logic             MemRead2,
    output logic             MemWrite1,
    output logic             MemWrite2,
    output logic [1:0]       MemDst1,
    output logic [1:0]       MemDst2,
    output logic [2:0]       MemData,
    output logic [2:0]       ALUOp,
    output logic             Halted,
    output logic             Illegal
);

    stateT      state, nextState;
    instrClassT instrClass;
    logic [2:0] decAluOp;
    logic       illegalReg;
    ctrlT       ctrl, ctrlOut;

    // Only the opcode field steers control; the operand bits belong to the datapath.
    logic unusedIrBits;
    assign unusedIrBits = ^IR[WIDTH-OPW-1:0];

    stack_opcode_decode #(.OPW(OPW)) uDecode (
        .opcode     (IR[WIDTH-1 -: OPW]),
        .instrClass (instrClass),
        .aluOp      (decAluOp)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= S_RESET;
            illegalReg <= 1'b0;
        end else begin
            state <= nextState;
            if (state == S_RESET)
                illegalReg <= 1'b0;
            else if (state == S_DECODE && instrClass == C_ILLEGAL)
                illegalReg <= 1'b1;
        end
    end

    // IR is only rewritten in FETCH, so the decoded class stays valid for
    // the whole instruction and can steer the shared POPA/READA states.
    always_comb begin
        nextState = state;
        case (state)
            S_RESET:    nextState = S_FETCH;
            S_FETCH:    nextState = S_DECODE;
            S_DECODE: begin
                case (instrClass)
                    C_NOP:   nextState = S_FETCH;
                    C_PUSHI: nextState = S_PUSH_IMM;
                    C_POP, C_ALU, C_BZ: nextState = S_POPA;
                    C_JMP:   nextState = S_BRANCH;
                    C_CALL:  nextState = S_RPUSH;
                    C_RET:   nextState = S_RPOP;
                    default: nextState = S_HALT;
                endcase
            end
            S_PUSH_IMM: nextState = S_FETCH;
            S_POPA:     nextState = (instrClass == C_POP) ? S_FETCH : S_READA;
            S_READA:    nextState = (instrClass == C_BZ) ? S_BZTEST : S_POPB;
            S_POPB:     nextState = S_READB;
            S_READB:    nextState = S_PUSH_RES;
            S_PUSH_RES: nextState = S_FETCH;
            S_BZTEST:   nextState = (ValA == '0) ? S_BRANCH : S_FETCH;
            S_BRANCH:   nextState = S_FETCH;
            S_RPUSH:    nextState = S_BRANCH;
            S_RPOP:     nextState = S_RREAD;
            S_RREAD:    nextState = S_JUMPR;
            S_JUMPR:    nextState = S_FETCH;
            S_HALT:     nextState = S_HALT;
            default:    nextState = S_RESET;
        endcase
    end

    // Output ROM keyed by state; unlisted fields stay zero.
    always_comb begin
        ctrl = '0;
        case (state)
            S_RESET: begin
                ctrl.mspRegReset = 1'b1;
                ctrl.rspRegReset = 1'b1;
                ctrl.pcRegReset  = 1'b1;
            end
            S_FETCH: begin
                ctrl.memDst1  = MEMDST1_PC;
                ctrl.memRead1 = 1'b1;
                ctrl.irWrite  = 1'b1;
                ctrl.pcWrite  = 1'b1;
            end
            S_PUSH_IMM: begin
                ctrl.memData   = MEMDATA_ZEIMM;
                ctrl.memWrite1 = 1'b1;
                ctrl.memDst1   = MEMDST1_MSP;
                ctrl.mspWrite  = 1'b1;
            end
            S_POPA, S_POPB: begin
                ctrl.mspWrite = 1'b1;
                ctrl.mspPop   = 1'b1;
            end
            S_READA: begin
                ctrl.memDst1   = MEMDST1_MSP;
                ctrl.memRead1  = 1'b1;
                ctrl.valAWrite = 1'b1;
            end
            S_READB: begin
                ctrl.memDst2   = MEMDST2_MSP;
                ctrl.memRead2  = 1'b1;
                ctrl.valBWrite = 1'b1;
            end
            S_PUSH_RES: begin
                // Result lands at MSP on port 1, then MSP increments.
                ctrl.memData   = MEMDATA_RES;
                ctrl.memWrite1 = 1'b1;
                ctrl.memDst1   = MEMDST1_MSP;
                ctrl.mspWrite  = 1'b1;
                ctrl.aluOp     = decAluOp;
            end
            S_BRANCH: begin
                ctrl.pcWrite = 1'b1;
                ctrl.pcAdd   = 1'b1;
            end
            S_RPUSH: begin
                ctrl.memDst2   = MEMDST2_RSP;
                ctrl.memData   = MEMDATA_PC;
                ctrl.memWrite2 = 1'b1;
                ctrl.rspWrite  = 1'b1;
            end
            S_RPOP: begin
                ctrl.rspWrite = 1'b1;
                ctrl.rspPop   = 1'b1;
            end
            S_RREAD: begin
                ctrl.memDst2   = MEMDST2_RSP;
                ctrl.memRead2  = 1'b1;
                ctrl.valAWrite = 1'b1;
            end
            S_JUMPR: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = 1'b1;
            end
            S_HALT:  ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

    assign ctrlOut = Reset ? '0 : ctrl;

    assign MSPWrite    = ctrlOut.mspWrite;
    assign MSPPop      = ctrlOut.mspPop;
    assign MSPRegReset = ctrlOut.mspRegReset;
    assign RSPWrite    = ctrlOut.rspWrite;
    assign RSPPop      = ctrlOut.rspPop;
    assign RSPRegReset = ctrlOut.rspRegReset;
    assign PCWrite     = ctrlOut.pcWrite;
    assign PCSource    = ctrlOut.pcSource;
    assign PCAdd       = ctrlOut.pcAdd;
    assign PCRegReset  = ctrlOut.pcRegReset;
    assign ValAWrite   = ctrlOut.valAWrite;
    assign ValBWrite   = ctrlOut.valBWrite;
    assign IRWrite     = ctrlOut.irWrite;
    assign MemRead1    = ctrlOut.memRead1;
    assign MemRead2    = ctrlOut.memRead2;
    assign MemWrite1   = ctrlOut.memWrite1;
    assign MemWrite2   = ctrlOut.memWrite2;
    assign MemDst1     = ctrlOut.memDst1;
    assign MemDst2     = ctrlOut.memDst2;
    assign MemData     = ctrlOut.memData;
    assign ALUOp       = ctrlOut.aluOp;
    assign Halted      = ctrlOut.halted;
    assign Illegal     = illegalReg;

endmodule
